// File: rtl/wb_uart_tx.sv
// Wishbone B3 classic slave: transmit FIFO feeding an 8N1 UART shifter.
// Registers at wb_adr_i[3:2]: 0 TXDATA, 1 STATUS, 2 DIVISOR, 3 CTRL.
module wb_uart_tx #(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        tx_o,
  output logic        irq_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic          ack_q, ack_d;
  logic [31:0]   dat_q, dat_d;
  logic [15:0]   div_q, div_d;
  logic          ie_q, ie_d;
  logic          ovf_q, ovf_d;
  logic          irq_q, irq_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  state_t        state_q;
  logic [15:0]   cnt_q;
  logic [15:0]   reload_q;
  logic [2:0]    bit_q;
  logic [7:0]    shreg_q;
  logic          tx_q;

  logic        access, wr_ack, full, empty, busy;
  logic        push_req, push, pop;
  logic [1:0]  reg_a;
  logic [31:0] rdata;
  logic [15:0] next_reload;
  logic [7:0]  fifo_rd;
  logic        unused_bits;

  assign reg_a    = wb_adr_i[3:2];
  assign access   = wb_cyc_i & wb_stb_i & ~ack_q;
  // Writes take effect at the end of the ack cycle; the master is still driving the bus then.
  assign wr_ack   = ack_q & wb_cyc_i & wb_stb_i & wb_we_i;
  assign full     = (level_q == LEVEL_FULL);
  assign empty    = (level_q == '0);
  assign busy     = (state_q != S_IDLE);
  assign push_req = wr_ack & (reg_a == 2'd0) & wb_sel_i[0];
  assign push     = push_req & ~full;
  assign pop      = ~empty & ((state_q == S_IDLE) | ((state_q == S_STOP) & (cnt_q == '0)));
  // A divisor of 0 behaves like 1: every bit lasts reload+1 cycles.
  assign next_reload = (div_q == '0) ? 16'd0 : div_q - 16'd1;
  assign fifo_rd     = mem_q[rd_ptr_q];
  assign unused_bits = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:16], wb_sel_i[3:2]};

  always_comb begin
    rdata = '0;
    case (reg_a)
      2'd1:    rdata = {16'd0, 8'(level_q), 4'd0, ovf_q, busy, empty, full};
      2'd2:    rdata = {16'd0, div_q};
      2'd3:    rdata = {31'd0, ie_q};
      default: rdata = '0;
    endcase
  end

  always_comb begin
    ack_d = access;
    dat_d = (access & ~wb_we_i) ? rdata : '0;
    div_d = div_q;
    ie_d  = ie_q;
    ovf_d = ovf_q;
    if (wr_ack) begin
      case (reg_a)
        2'd1: if (wb_sel_i[0] & wb_dat_i[3]) ovf_d = 1'b0;
        2'd2: begin
          if (wb_sel_i[0]) div_d[7:0]  = wb_dat_i[7:0];
          if (wb_sel_i[1]) div_d[15:8] = wb_dat_i[15:8];
        end
        2'd3: if (wb_sel_i[0]) ie_d = wb_dat_i[0];
        default: ;
      endcase
    end
    if (push_req & full) ovf_d = 1'b1;

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    irq_d = ie_q & empty & ~busy;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      div_q    <= DIV_RESET;
      ie_q     <= 1'b0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      div_q    <= div_d;
      ie_q     <= ie_d;
      ovf_q    <= ovf_d;
      irq_q    <= irq_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wb_dat_i[7:0];
  end

  // Shifter; the divisor is latched per frame so mid-frame writes only affect later frames.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      reload_q <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      tx_q     <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            shreg_q  <= fifo_rd;
            reload_q <= next_reload;
            cnt_q    <= next_reload;
            tx_q     <= 1'b0;
            state_q  <= S_START;
          end
        end
        S_START: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 16'd1;
          end else begin
            cnt_q   <= reload_q;
            bit_q   <= '0;
            tx_q    <= shreg_q[0];
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 16'd1;
          end else begin
            cnt_q <= reload_q;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= S_STOP;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shreg_q <= {1'b0, shreg_q[7:1]};
              tx_q    <= shreg_q[1];
            end
          end
        end
        S_STOP: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 16'd1;
          end else if (pop) begin
            shreg_q  <= fifo_rd;
            reload_q <= next_reload;
            cnt_q    <= next_reload;
            tx_q     <= 1'b0;
            state_q  <= S_START;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign tx_o     = tx_q;
  assign irq_o    = irq_q;

endmodule

// File: tb/tb_wb_uart_tx.sv
// Scoreboard bench for wb_uart_tx: bus reads and UART frames are checked by
// monitors against expectations queued from a behavioural model.
module tb_wb_uart_tx;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] adr = '0, dat_i = '0, dat_o;
  logic [3:0]  sel = '0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic        ack, tx, irq;

  wb_uart_tx #(.FIFO_DEPTH(DEPTH), .DIV_RESET(16'd434)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .wb_adr_i(adr), .wb_dat_i(dat_i),
    .wb_sel_i(sel), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_dat_o(dat_o), .wb_ack_o(ack), .tx_o(tx), .irq_o(irq)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  typedef struct { logic [7:0] b; int p; } frame_t;
  typedef struct { string nm; logic [31:0] v; } rd_t;
  frame_t exp_tx[$];
  rd_t    exp_rd[$];
  int     starts[$];

  // Behavioural model: m_wait = bytes waiting in the FIFO, m_busy = a frame is owned by the shifter
  logic [15:0] m_div = 16'd434;
  bit m_ie = 0, m_ovf = 0, m_busy = 0;
  int m_wait = 0;
  int frames_done = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    return (32'(m_wait) << 8) | (32'(m_ovf) << 3) | (32'(m_busy) << 2) |
           (32'(m_wait == 0) << 1) | 32'(m_wait == DEPTH);
  endfunction

  task automatic model_reset();
    m_div = 16'd434; m_ie = 0; m_ovf = 0; m_busy = 0; m_wait = 0;
    exp_tx.delete();
  endtask

  task automatic model_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
    frame_t f;
    case (a)
      2'd0: if (s[0]) begin
        if (m_wait == DEPTH) m_ovf = 1;
        else begin
          f.b = d[7:0];
          f.p = (m_div == 0) ? 1 : int'(m_div);
          exp_tx.push_back(f);
          if (!m_busy && m_wait == 0) m_busy = 1;
          else m_wait++;
        end
      end
      2'd1: if (s[0] && d[3]) m_ovf = 0;
      2'd2: begin
        if (s[0]) m_div[7:0]  = d[7:0];
        if (s[1]) m_div[15:8] = d[15:8];
      end
      default: if (s[0]) m_ie = d[0];
    endcase
  endtask

  task automatic bus(input bit w, input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    @(posedge clk); #1;
    adr = {28'd0, a, 2'b00}; dat_i = d; sel = s; we = w; cyc = 1; stb = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!ack && n < 20);
    checks++;
    if (!ack) begin
      errors++;
      $display("FAIL bus_ack_timeout: no ack after %0d cycles, expected ack within 2", n);
    end else if (w) model_write(a, d, s);
    @(posedge clk); #1;
    cyc = 0; stb = 0; we = 0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
    bus(1, a, d, s);
  endtask

  task automatic rd(input string nm, input logic [1:0] a);
    rd_t r;
    r.nm = nm;
    case (a)
      2'd0: r.v = 0;
      2'd1: r.v = m_status();
      2'd2: r.v = {16'd0, m_div};
      default: r.v = {31'd0, m_ie};
    endcase
    exp_rd.push_back(r);
    bus(0, a, 0, 4'hF);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic wait_starts(input int k, input int budget);
    int n = 0;
    while (starts.size() < k && n < budget) begin @(negedge clk); n++; end
    checks++;
    if (starts.size() < k) begin
      errors++;
      $display("FAIL frame_start_timeout: saw %0d frame starts, expected %0d", starts.size(), k);
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((m_busy || exp_tx.size() != 0 || rx_on) && n < budget) begin @(negedge clk); n++; end
    checks++;
    if (m_busy || exp_tx.size() != 0 || rx_on) begin
      errors++;
      $display("FAIL drain_timeout: %0d frames still outstanding, expected 0", exp_tx.size());
    end
  endtask

  // Read-data monitor and single-cycle ack check
  logic ack_prev = 1'b0;
  always @(negedge clk) begin
    rd_t r;
    if (ack) begin
      checks++;
      if (ack_prev) begin
        errors++;
        $display("FAIL ack_pulse: ack high 2 cycles in a row, expected 1-cycle pulse");
      end
      if (!we) begin
        if (exp_rd.size() == 0) begin
          checks++; errors++;
          $display("FAIL read_unexpected: read ack with data 0x%08h, expected no read", dat_o);
        end else begin
          r = exp_rd.pop_front();
          chk(r.nm, dat_o, r.v);
        end
      end
    end
    ack_prev = ack;
  end

  // UART line monitor: every cycle of every frame must match the expected bit
  bit rx_on = 0, rx_bad = 0, rx_junk = 0;
  int rx_c = 0, rx_p = 1;
  logic [9:0] rx_bits, rx_cap;
  always @(negedge clk) begin
    frame_t f;
    if (!rst_n) begin
      rx_on = 0; rx_junk = 0;
    end else begin
      if (tx === 1'b1) rx_junk = 0;
      if (!rx_on && !rx_junk && tx === 1'b0) begin
        if (exp_tx.size() == 0) begin
          checks++; errors++; rx_junk = 1;
          $display("FAIL tx_unexpected: start bit at cycle %0d, expected idle line", cyc_n);
        end else begin
          f = exp_tx.pop_front();
          rx_on = 1; rx_c = 0; rx_p = f.p; rx_bad = 0; rx_cap = '0;
          rx_bits = {1'b1, f.b, 1'b0};
          starts.push_back(cyc_n);
        end
      end
      if (rx_on) begin
        if (tx !== rx_bits[rx_c / rx_p]) rx_bad = 1;
        if (rx_c % rx_p == rx_p / 2) rx_cap[rx_c / rx_p] = tx;
        rx_c++;
        if (rx_c == 10 * rx_p) begin
          checks++;
          if (rx_bad) begin
            errors++;
            $display("FAIL tx_frame: line bits got %b expected %b (period %0d, stop..start)",
                     rx_cap, rx_bits, rx_p);
          end
          rx_on = 0;
          frames_done++;
          if (m_wait > 0) m_wait--;
          else m_busy = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    int t_irq, n;
    logic [7:0] b;
    logic [15:0] d;
    repeat (3) @(negedge clk);
    chk("reset_tx", 32'(tx), 1);
    chk("reset_irq", 32'(irq), 0);
    chk("reset_ack", 32'(ack), 0);
    chk("reset_dat", dat_o, 0);
    @(posedge clk); #1 rst_n = 1;

    rd("status_after_reset", 2'd1);
    rd("divisor_after_reset", 2'd2);
    rd("ctrl_after_reset", 2'd3);
    rd("txdata_reads_zero", 2'd0);

    // single frame, DIV=4
    wr(2'd2, 32'd4);
    wr(2'd0, 32'h55);
    idle(4);
    rd("status_busy_0x55", 2'd1);
    drain(200);
    idle(3);
    rd("status_idle_0x55", 2'd1);

    // back-to-back frames, DIV=2
    wr(2'd2, 32'd2);
    starts.delete();
    wr(2'd0, 32'h41); wr(2'd0, 32'h42); wr(2'd0, 32'h43);
    idle(2);
    rd("level_frame1", 2'd1);
    wait_starts(2, 100); idle(3);
    rd("level_frame2", 2'd1);
    wait_starts(3, 100); idle(3);
    rd("level_frame3", 2'd1);
    drain(200);
    if (starts.size() == 3) begin
      chk("gap_frame1_2", 32'(starts[1] - starts[0]), 20);
      chk("gap_frame2_3", 32'(starts[2] - starts[1]), 20);
    end

    // divisor write mid-frame affects only the next frame
    wr(2'd2, 32'd3);
    starts.delete();
    wr(2'd0, 32'hA5);
    wait_starts(1, 50);
    wr(2'd2, 32'd5);
    wr(2'd0, 32'h3C);
    rd("divisor_mid_frame", 2'd2);
    drain(300);

    // randomized frames including DIV=0
    for (int it = 0; it < 6; it++) begin
      d = (it == 0) ? 16'd0 : 16'($urandom_range(0, 5));
      wr(2'd2, {16'd0, d});
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom);
        wr(2'd0, {24'd0, b});
      end
      drain(1000);
      idle(2);
      rd("divisor_random", 2'd2);
    end

    // interrupt timing
    wr(2'd3, 32'd1);
    idle(3);
    @(negedge clk);
    chk("irq_idle_ie", 32'(irq), 1);
    rd("ctrl_ie", 2'd3);
    wr(2'd2, 32'd3);
    starts.delete();
    wr(2'd0, 32'hFF);
    idle(2);
    @(negedge clk);
    chk("irq_after_push", 32'(irq), 0);
    n = 0;
    while (!irq && n < 100) begin @(negedge clk); n++; end
    t_irq = cyc_n;
    if (starts.size() >= 1) chk("irq_rise_cycle", 32'(t_irq), 32'(starts[0] + 31));
    else chk("irq_frame_seen", 32'(starts.size()), 1);
    drain(100);

    // asynchronous reset mid-frame
    starts.delete();
    wr(2'd0, 32'h00);
    wait_starts(1, 50);
    idle(5);
    #3 rst_n = 0;
    #1;
    chk("rst_tx_high", 32'(tx), 1);
    chk("rst_irq_low", 32'(irq), 0);
    chk("rst_ack_low", 32'(ack), 0);
    model_reset();
    idle(2); #1 rst_n = 1;
    rd("status_after_abort", 2'd1);
    rd("divisor_after_abort", 2'd2);

    // FIFO full and overflow, DIV=1000
    wr(2'd2, 32'd1000);
    for (int k = 0; k < 17; k++) wr(2'd0, 32'($urandom_range(0, 255)));
    idle(3);
    rd("status_full_no_ovf", 2'd1);
    wr(2'd0, 32'h99);
    rd("status_full_ovf", 2'd1);
    wr(2'd1, 32'h8, 4'h1);
    rd("status_ovf_cleared", 2'd1);
    @(negedge clk); #2 rst_n = 0;
    model_reset();
    idle(2); #1 rst_n = 1;

    // byte lanes
    wr(2'd2, 32'h0000_0700, 4'b0010);
    rd("divisor_lane1", 2'd2);
    wr(2'd0, 32'h0000_0061, 4'b0000);
    idle(10);
    rd("status_sel0_nopush", 2'd1);

    idle(5);
    chk("read_queue_empty", 32'(exp_rd.size()), 0);
    chk("frame_queue_empty", 32'(exp_tx.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
